// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared widths and FSM state type for the sequential
// restoring divider (seq_divider) and its single-step datapath (div_step).
package seq_divider_pkg;

  // Default operand widths, matched to the paired MAC_UNIT multiplier.
  localparam int unsigned A_WIDTH_DEF = 7;
  localparam int unsigned B_WIDTH_DEF = 4;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational radix-2 restoring division step.
// Ports:
//   part_i    : current partial remainder (B_WIDTH+1 bits)
//   bit_i     : next dividend bit, shifted in at the LSB
//   divisor_i : divisor
//   part_o    : next partial remainder
//   qbit_o    : quotient bit produced by this step
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned B_WIDTH = B_WIDTH_DEF
) (
  input  logic [B_WIDTH:0]   part_i,
  input  logic               bit_i,
  input  logic [B_WIDTH-1:0] divisor_i,
  output logic [B_WIDTH:0]   part_o,
  output logic               qbit_o
);

  localparam int unsigned PW = B_WIDTH + 1;
  localparam int unsigned SW = B_WIDTH + 2;

  logic [SW-1:0] shifted;
  logic [SW-1:0] dvs_ext;

  // Shift in the dividend bit; one extra MSB keeps the compare exact.
  assign shifted = {part_i, bit_i};
  assign dvs_ext = SW'(divisor_i);

  // Trial subtraction is non-negative exactly when shifted >= divisor.
  assign qbit_o = (shifted >= dvs_ext);
  assign part_o = qbit_o ? PW'(shifted - dvs_ext) : PW'(shifted);

endmodule : div_step

// File: rtl/seq_divider.sv
// seq_divider: sequential radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   Dividend, Divisor   : unsigned operands (DVD_WIDTH / B_WIDTH bits)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   Quotient, Remainder : result, held until the next result or reset
//   div_by_zero         : result came from a zero divisor
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int unsigned A_WIDTH   = A_WIDTH_DEF,
  parameter  int unsigned B_WIDTH   = B_WIDTH_DEF,
  localparam int unsigned DVD_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DVD_WIDTH-1:0] Dividend,
  input  logic [B_WIDTH-1:0]   Divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DVD_WIDTH-1:0] Quotient,
  output logic [B_WIDTH-1:0]   Remainder,
  output logic                 div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DVD_WIDTH + 1);
  localparam int unsigned PW    = B_WIDTH + 1;

  state_e               state_q,     state_d;
  logic [DVD_WIDTH-1:0] dvd_q,       dvd_d;
  logic [B_WIDTH-1:0]   dvs_q,       dvs_d;
  logic [B_WIDTH-1:0]   dvd_lo_q,    dvd_lo_d;
  logic [PW-1:0]        part_q,      part_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [DVD_WIDTH-1:0] quo_q,       quo_d;
  logic [B_WIDTH-1:0]   rem_q,       rem_d;
  logic                 dbz_q,       dbz_d;

  logic [PW-1:0]        step_part;
  logic                 step_qbit;

  // Single shared restoring step fed from the dividend MSB.
  div_step #(
    .B_WIDTH (B_WIDTH)
  ) u_step (
    .part_i    (part_q),
    .bit_i     (dvd_q[DVD_WIDTH-1]),
    .divisor_i (dvs_q),
    .part_o    (step_part),
    .qbit_o    (step_qbit)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    dvd_lo_d    = dvd_lo_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = ST_BUSY;
          dvd_d      = Dividend;
          dvs_d      = Divisor;
          dvd_lo_d   = Dividend[B_WIDTH-1:0];
          part_d     = '0;
          cnt_d      = CNT_W'(DVD_WIDTH - 1);
          in_ready_d = 1'b0;
        end
      end

      ST_BUSY: begin
        // Dividend register doubles as the quotient shift register.
        dvd_d  = {dvd_q[DVD_WIDTH-2:0], step_qbit};
        part_d = step_part;
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          if (dvs_q == '0) begin
            // Zero divisor: iteration ran for uniform latency, result is forced.
            quo_d = '1;
            rem_d = dvd_lo_q;
            dbz_d = 1'b1;
          end else begin
            quo_d = {dvd_q[DVD_WIDTH-2:0], step_qbit};
            rem_d = step_part[B_WIDTH-1:0];
            dbz_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Result fields keep their value after the handshake.
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvd_lo_q    <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      dvd_lo_q    <= dvd_lo_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign Quotient    = quo_q;
  assign Remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an
// arithmetic reference (integer / and %, plus the zero-divisor rule).
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int unsigned AW  = A_WIDTH_DEF;
  localparam int unsigned BW  = B_WIDTH_DEF;
  localparam int unsigned DW  = AW + BW;
  localparam int unsigned LAT = DW;
  localparam int unsigned II  = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] Dividend;
  logic [BW-1:0] Divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Quotient;
  logic [BW-1:0] Remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seq_divider #(
    .A_WIDTH (AW),
    .B_WIDTH (BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference division from the arithmetic definition.
  function automatic void model(input int dvd, input int dvs,
                                output int q, output int r, output int z);
    if (dvs == 0) begin
      q = (1 << DW) - 1;
      r = dvd % (1 << BW);
      z = 1;
    end else begin
      q = dvd / dvs;
      r = dvd % dvs;
      z = 0;
    end
  endfunction

  // Present operands and return 1 ns after the accepting edge.
  task automatic send(input int dvd, input int dvs);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    Dividend = DW'(dvd);
    Divisor  = BW'(dvs);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("result_valid", 64'(out_valid), 64'(1));
  endtask

  task automatic check_result(input string tag, input int dvd, input int dvs);
    int q, r, z;
    model(dvd, dvs, q, r, z);
    chk({tag, "_quotient"},  64'(Quotient),    64'(q));
    chk({tag, "_remainder"}, 64'(Remainder),   64'(r));
    chk({tag, "_dbz"},       64'(div_by_zero), 64'(z));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ready_after_take"}, 64'(in_ready),  64'(1));
    chk({tag, "_valid_after_take"}, 64'(out_valid), 64'(0));
  endtask

  task automatic run_op(input string tag, input int dvd, input int dvs);
    int lat;
    send(dvd, dvs);
    chk({tag, "_busy_ready"}, 64'(in_ready), 64'(0));
    wait_result(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    check_result(tag, dvd, dvs);
    take(tag);
  endtask

  initial begin
    int lat, a, b, ea, acc, prev_acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Dividend  = '0;
    Divisor   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),    64'(1));
    chk("rst_out_valid", 64'(out_valid),   64'(0));
    chk("rst_quotient",  64'(Quotient),    64'(0));
    chk("rst_remainder", 64'(Remainder),   64'(0));
    chk("rst_dbz",       64'(div_by_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, corners and divide-by-zero.
    run_op("basic_1000_7", 1000, 7);
    run_op("max_by_1",     2047, 1);
    run_op("small_5_9",    5,    9);
    run_op("max_by_15",    2047, 15);
    run_op("dbz_1234",     1234, 0);

    // Backpressure: result held, a new request ignored while in DONE.
    send(777, 5);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        Dividend = DW'(100);
        Divisor  = BW'(3);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_valid_held", 64'(out_valid), 64'(1));
      chk("bp_ready_low",  64'(in_ready),  64'(0));
      check_result("bp_hold", 777, 5);
    end
    in_valid = 1'b0;
    take("bp");
    chk("bp_quotient_kept", 64'(Quotient), 64'(777 / 5));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("bp_pulse_ignored_valid", 64'(out_valid), 64'(0));
    chk("bp_pulse_ignored_ready", 64'(in_ready),  64'(1));

    // Reset five cycles into an operation.
    send(1000, 7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(in_ready),    64'(1));
    chk("mid_rst_out_valid", 64'(out_valid),   64'(0));
    chk("mid_rst_quotient",  64'(Quotient),    64'(0));
    chk("mid_rst_remainder", 64'(Remainder),   64'(0));
    chk("mid_rst_dbz",       64'(div_by_zero), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DW + 3) begin
      @(posedge clk);
      #1;
    end
    chk("mid_rst_no_stale_result", 64'(out_valid), 64'(0));
    run_op("post_rst_100_10", 100, 10);

    // Round trip (a*b)/b = a, back-to-back with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = int'($urandom_range((1 << AW) - 1, 0));
    b = int'($urandom_range((1 << BW) - 1, 1));
    Dividend = DW'(a * b);
    Divisor  = BW'(b);
    prev_acc = 0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      int k;
      k = 0;
      while (!in_ready && k < 64) begin
        @(negedge clk);
        k++;
      end
      chk("rt_accept_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      acc = cyc;
      if (i > 0) chk("rt_interval", 64'(acc - prev_acc), 64'(II));
      prev_acc = acc;
      ea = a;
      if (i == 39) begin
        in_valid = 1'b0;
      end else begin
        a = int'($urandom_range((1 << AW) - 1, 0));
        b = int'($urandom_range((1 << BW) - 1, 1));
        Dividend = DW'(a * b);
        Divisor  = BW'(b);
      end
      wait_result(lat);
      chk("rt_latency",   64'(lat),         64'(LAT));
      chk("rt_quotient",  64'(Quotient),    64'(ea));
      chk("rt_remainder", 64'(Remainder),   64'(0));
      chk("rt_dbz",       64'(div_by_zero), 64'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("rt_final_ready", 64'(in_ready),  64'(1));
    chk("rt_final_valid", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_divider
